uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares a single UART_tx between NUM_REQ requesters using round-robin arbitration.
- Sequences each transfer as an optional ID header byte followed by a payload byte.
- Drives UART_tx's trmt/tx_data and waits on its tx_done for each byte.
- Returns a one-cycle ack to the served requester once both bytes are fully shifted out.
- Sits between the byte sources (counter, push-button logic, other producers) and UART_tx in the UART test/bring-up path.

Parameters:
- NUM_REQ, 4: number of requesters; 2..16.
- HEADER_EN, 1: 1 sends the header byte before the payload; 0 sends the payload only.
- HDR_BASE, 8'hA0: header byte is HDR_BASE + requester ID (8-bit add, wraps mod 256).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req  input  NUM_REQ  per-requester level request; held until matching ack
- req_data  input  8*NUM_REQ  payload byte of requester i is req_data[8*i+7:8*i]
- ack  output  NUM_REQ  one-cycle pulse on bit i when requester i's transfer completes
- busy  output  1  high in every state except IDLE
- cur_id  output  4  ID of the granted requester; valid while busy
- trmt  output  1  one-cycle start strobe to UART_tx
- tx_data  output  8  byte to UART_tx
- tx_done  input  1  UART_tx done flag (level; cleared by UART_tx on trmt)

Behaviour:
- Synchronous active-high reset, sampled on the clk rising edge only. It forces:
  - state=IDLE; trmt=0, ack=0, busy=0, tx_data=8'h00, cur_id=0;
  - round-robin pointer last=NUM_REQ-1, so requester 0 has first priority;
  - done_q=0.
- Reset mid-transfer aborts immediately: no ack is issued and UART_tx is not re-strobed. Any byte already in flight finishes on the line without being tracked.
- Done detect: done_q registers tx_done every cycle. done_rise = tx_done & ~done_q. Only done_rise advances the WAIT states, so a stale high tx_done left over from a previous byte is ignored.
- States: IDLE, GRANT, SEND_HDR, WAIT_HDR, SEND_DAT, WAIT_DAT, ACK.
- IDLE: if req != 0, go to GRANT next cycle; else stay.
- GRANT (1 cycle):
  - Select the first i with req[i]=1, searching last+1, last+2, ... modulo NUM_REQ.
  - Latch cur_id=i and the payload register = req_data[i]; set last=i.
  - Next state is SEND_HDR if HEADER_EN=1, else SEND_DAT.
  - If req dropped to all-zero between IDLE and GRANT, return to IDLE with no side effects.
- SEND_HDR (1 cycle): trmt=1, tx_data=HDR_BASE+cur_id. Next state WAIT_HDR.
- WAIT_HDR: tx_data held; on done_rise go to SEND_DAT.
- SEND_DAT (1 cycle): trmt=1, tx_data=latched payload. Next state WAIT_DAT.
- WAIT_DAT: tx_data held; on done_rise go to ACK.
- ACK (1 cycle): ack[cur_id]=1, all other ack bits 0. Next state IDLE.
- Registered outputs: trmt, ack and tx_data are registered, so each is valid in the cycle its state is occupied. trmt is high for exactly one cycle per byte and is never asserted in WAIT/ACK/IDLE.
- Payload is latched at GRANT. Later changes to req_data, or req dropping mid-transfer, do not affect the bytes sent or the ack.
- The requester must drop req in the cycle after ack. A req still high in IDLE is treated as a new request, which round-robin places last.
- Minimum turnaround between transfers: ACK→IDLE→GRANT, i.e. two idle cycles after ack before the next trmt.
- Throughput: one transfer per 2 UART frames + 5 cycles (HEADER_EN=1); 1 frame + 4 cycles (HEADER_EN=0).
- No timeout: a tx_done that never rises stalls the block in a WAIT state until rst.

Test Plan:
- Single request, HEADER_EN=1:
  - Stimulus: req=4'b0100, req_data[23:16]=8'h5C.
  - Required: trmt with 8'hA2, then trmt with 8'h5C after the first done_rise; ack=4'b0100 for one cycle after the second done_rise; busy low afterwards.
- All four requesting continuously from reset:
  - Required: grant order 0,1,2,3,0,...
  - Required: header bytes A0,A1,A2,A3; no requester is served twice before the others are served once.
- Stale done:
  - Stimulus: hold tx_done=1 from reset, then req[1]=1.
  - Required: header is sent and the block stays in WAIT_HDR until tx_done falls then rises; no early advance.
- req_data and req change mid-transfer:
  - Stimulus: req[0] with payload 8'h11; change req_data[7:0] to 8'hEE during WAIT_HDR; drop req[0].
  - Required: the payload sent is 8'h11 and ack[0] still pulses.
- Reset mid-transfer:
  - Stimulus: assert rst during WAIT_DAT.
  - Required: next cycle state=IDLE, busy=0, trmt=0, ack=0. After release with req=4'b1010, requester 1 is granted first (pointer reset).
- HEADER_EN=0, HDR_BASE=8'hFF:
  - Stimulus: req[3] with payload 8'h7E.
  - Required: exactly one trmt, with 8'h7E; ack[3] pulses after one done_rise.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART_tx between NUM_REQ byte producers. Requests are served
// round-robin. Each transfer is an optional header byte (HDR_BASE + ID)
// followed by the requester's payload byte. A one-cycle ack goes back to the
// served requester once both bytes have been shifted out.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   req       per-requester level request, held until its ack
//   req_data  payload bytes, requester i at [8*i+7:8*i]
//   ack       one-cycle completion pulse, bit i for requester i
//   busy      high whenever the FSM is not idle
//   cur_id    granted requester ID, valid while busy
//   trmt      one-cycle start strobe to UART_tx
//   tx_data   byte presented to UART_tx
//   tx_done   UART_tx done flag (level, cleared by UART_tx on trmt)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int          NUM_REQ   = 4,
    parameter bit          HEADER_EN = 1'b1,
    parameter logic [7:0]  HDR_BASE  = 8'hA0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   busy,
    output logic [3:0]             cur_id,
    output logic                   trmt,
    output logic [7:0]             tx_data,
    input  logic                   tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_SEND_HDR,
        S_WAIT_HDR,
        S_SEND_DAT,
        S_WAIT_DAT,
        S_ACK
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic                 r_done_q;
    logic [3:0]           r_last;
    logic [3:0]           r_cur_id;
    logic [7:0]           r_payload;
    logic                 r_trmt;
    logic [NUM_REQ-1:0]   r_ack;
    logic [7:0]           r_tx_data;

    logic                 w_done_rise;
    logic                 w_hit;
    logic [3:0]           w_sel;
    logic [7:0]           w_pay;
    logic                 w_grant;
    logic                 w_trmt;
    logic [NUM_REQ-1:0]   w_ack;
    logic [7:0]           w_txd;

    // Only a fresh rising edge counts, so a done flag left high from the
    // previous byte cannot advance a wait state.
    assign w_done_rise = tx_done & ~r_done_q;

    // Round-robin pick: lowest index above r_last wins, otherwise lowest
    // index at or below r_last. Descending loops overwrite so the lowest
    // index of each group survives; the second loop takes precedence.
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        w_pay = '0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (req[i] && (i <= int'(r_last))) begin
                w_hit = 1'b1;
                w_sel = 4'(i);
                w_pay = req_data[8*i +: 8];
            end
        end
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (req[i] && (i > int'(r_last))) begin
                w_hit = 1'b1;
                w_sel = 4'(i);
                w_pay = req_data[8*i +: 8];
            end
        end
    end

    // Next state plus the values the output registers take on entry to that
    // state, so trmt/ack/tx_data line up with the state being occupied.
    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_trmt  = 1'b0;
        w_ack   = '0;
        w_txd   = r_tx_data;
        case (r_state)
            S_IDLE: begin
                if (|req) w_next = S_GRANT;
            end
            S_GRANT: begin
                if (w_hit) begin
                    w_grant = 1'b1;
                    w_trmt  = 1'b1;
                    if (HEADER_EN) begin
                        w_next = S_SEND_HDR;
                        w_txd  = HDR_BASE + {4'h0, w_sel};
                    end else begin
                        w_next = S_SEND_DAT;
                        w_txd  = w_pay;
                    end
                end else begin
                    // request withdrawn before grant: nothing latched
                    w_next = S_IDLE;
                end
            end
            S_SEND_HDR: w_next = S_WAIT_HDR;
            S_WAIT_HDR: begin
                if (w_done_rise) begin
                    w_next = S_SEND_DAT;
                    w_trmt = 1'b1;
                    w_txd  = r_payload;
                end
            end
            S_SEND_DAT: w_next = S_WAIT_DAT;
            S_WAIT_DAT: begin
                if (w_done_rise) begin
                    w_next = S_ACK;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (r_cur_id == 4'(i)) w_ack[i] = 1'b1;
                    end
                end
            end
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_q  <= 1'b0;
            r_last    <= 4'(NUM_REQ-1);
            r_cur_id  <= '0;
            r_payload <= '0;
            r_trmt    <= 1'b0;
            r_ack     <= '0;
            r_tx_data <= '0;
        end else begin
            r_done_q  <= tx_done;
            r_trmt    <= w_trmt;
            r_ack     <= w_ack;
            r_tx_data <= w_txd;
            if (w_grant) begin
                r_last    <= w_sel;
                r_cur_id  <= w_sel;
                r_payload <= w_pay;
            end
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign cur_id  = r_cur_id;
    assign trmt    = r_trmt;
    assign ack     = r_ack;
    assign tx_data = r_tx_data;

endmodule
